// File: rtl/fpga_bootrom_pkg.sv
// Shared constants and response record for the FPGA boot ROM arbiter.
package fpga_bootrom_pkg;

  localparam int BOOTROM_DATA_WIDTH = 32;
  localparam int BOOTROM_WORDS      = 118;

  // Wide enough to name any of up to 8 requesters.
  localparam int BOOTROM_ID_WIDTH   = 3;

  // Registered response: valid flag, owning requester and error flag.
  typedef struct packed {
    logic                        vld;
    logic [BOOTROM_ID_WIDTH-1:0] id;
    logic                        err;
  } bootrom_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at index ptr and wraps modulo N; the first set request
// wins. gnt is one-hot or zero, idx is the winning index, any flags a winner.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotate the priority so that index ptr is examined first.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_bootrom_arbiter.sv
// Round-robin arbiter sharing the single-port FPGA boot ROM between NUM_REQ
// requesters. One access may be granted every cycle; the read response
// returns exactly one cycle after its grant.
//
// Optional build macro FPGA_BOOTROM_RANGE_CHECK_EN: accesses beyond the
// populated ROM (word index >= ROM_WORDS, or non-zero address bits above the
// ROM word address) are granted but not issued to the ROM, and answer with
// rdata_o = 0 and err_o = 1.
//
// Handshake (PULP req/gnt/rvalid): a requester raises req_i with addr_i and
// holds both stable until gnt_o for that requester is seen high in the same
// cycle; the grant is combinational and never retracted within the cycle.
// Exactly one cycle after the grant, rvalid_o for that requester is high for
// one cycle with rdata_o (and err_o) valid. There is no back-pressure on the
// response side, so grants may be issued back-to-back.
module fpga_bootrom_arbiter
  import fpga_bootrom_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int ROM_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = BOOTROM_DATA_WIDTH,
  parameter int ROM_WORDS      = BOOTROM_WORDS
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 err_o,
  output logic                                 rom_cen_o,
  output logic [ROM_ADDR_WIDTH-1:0]            rom_a_o,
  input  logic [DATA_WIDTH-1:0]                rom_q_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guard on the parameter space this block supports.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (DATA_WIDTH != 32) ||
      (ROM_WORDS > (1 << ROM_ADDR_WIDTH)) || (ADDR_WIDTH < ROM_ADDR_WIDTH + 2)) begin : g_bad_params
    $error("fpga_bootrom_arbiter: unsupported parameter combination");
  end

  // State
  logic [IW-1:0]             r_rr_ptr;
  bootrom_resp_t             r_resp;
  logic [ROM_ADDR_WIDTH-1:0] r_last_a;

  // Arbitration and address path
  logic [NUM_REQ-1:0]        w_arb_gnt;
  logic [IW-1:0]             w_win;
  logic                      w_arb_any;
  logic                      w_grant;
  logic [IW-1:0]             w_ptr_nxt;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic [ROM_ADDR_WIDTH-1:0] w_word;
  logic                      w_oob;
  logic                      w_unused;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req (req_i),
    .ptr (r_rr_ptr),
    .gnt (w_arb_gnt),
    .idx (w_win),
    .any (w_arb_any)
  );

  // Reset suppresses every grant, whatever the requesters drive.
  assign w_grant = w_arb_any & ~RST;
  assign gnt_o   = RST ? '0 : w_arb_gnt;

  // Winner's byte address reduced to a ROM word address; byte offset dropped.
  assign w_addr  = addr_i[w_win];
  assign w_word  = w_addr[ROM_ADDR_WIDTH+1:2];

`ifdef FPGA_BOOTROM_RANGE_CHECK_EN
  assign w_oob   = w_grant &&
                   ((int'(w_word) >= ROM_WORDS) ||
                    ((w_addr >> (ROM_ADDR_WIDTH + 2)) != '0));
`else
  assign w_oob   = 1'b0;
`endif

  // Byte offsets (and upper bits without the range check) are not decoded.
  assign w_unused = ^addr_i;

  // Pointer moves just past the winner so it drops to lowest priority.
  assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;

  // ROM is enabled only for an in-range grant; the address holds when idle.
  assign rom_cen_o = ~(w_grant & ~w_oob);
  assign rom_a_o   = w_grant ? w_word : r_last_a;

  // Round-robin pointer, response record and last driven ROM address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr <= '0;
      r_resp   <= '0;
      r_last_a <= '0;
    end else begin
      r_resp.vld <= w_grant;
      r_resp.id  <= BOOTROM_ID_WIDTH'(w_win);
      r_resp.err <= w_oob;
      if (w_grant) begin
        r_rr_ptr <= w_ptr_nxt;
        r_last_a <= w_word;
      end
    end
  end

  // Route the response valid to the requester that owns it; a response
  // still in flight when reset arrives is dropped.
  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_resp.vld && !RST && (int'(r_resp.id) == i)) begin
        rvalid_o[i] = 1'b1;
      end
    end
  end

`ifdef FPGA_BOOTROM_RANGE_CHECK_EN
  assign rdata_o = r_resp.err ? '0 : rom_q_i;
`else
  assign rdata_o = rom_q_i;
`endif

  assign err_o = r_resp.err & ~RST;

endmodule

// File: tb/tb_fpga_bootrom_arbiter.sv
// Self-checking bench for fpga_bootrom_arbiter with a registered ROM model,
// a reference round-robin model and a response scoreboard.
module tb_fpga_bootrom_arbiter;

  localparam int NR = 3;
  localparam int W  = 36;  // {id[2:0], err, data[31:0]}

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        req;
  logic [NR-1:0][31:0]  addr;
  logic [NR-1:0]        gnt_o;
  logic [NR-1:0]        rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;
  logic                 rom_cen_o;
  logic [6:0]           rom_a_o;
  logic [31:0]          rom_q;

  logic [31:0]          mem [0:127];
  logic [W-1:0]         exp_q[$];

  int                   checks = 0;
  int                   errors = 0;
  int                   ptr_m = 0;
  logic [6:0]           last_a_m = '0;
  int                   wait_cnt [NR];
  logic [NR-1:0]        gnt_seen = '0;

  fpga_bootrom_arbiter dut (
    .CLK       (clk),
    .RST       (rst),
    .req_i     (req),
    .addr_i    (addr),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .rom_cen_o (rom_cen_o),
    .rom_a_o   (rom_a_o),
    .rom_q_i   (rom_q)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port ROM model
  always @(posedge clk) begin
    if (!rom_cen_o) rom_q <= mem[rom_a_o];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic oob_of(input logic [31:0] a);
`ifdef FPGA_BOOTROM_RANGE_CHECK_EN
    return (a[8:2] >= 7'd118) || (a[31:9] != 23'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: reference arbiter plus scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    int            win;
    logic [NR-1:0] eg;
    logic [W-1:0]  e;
    logic [6:0]    wd;
    logic          oob;
    gnt_seen = gnt_o;
    if (rst) begin
      chk("rst_gnt", gnt_o, 0);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_cen", rom_cen_o, 1);
      exp_q.delete();
      ptr_m    = 0;
      last_a_m = '0;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_rvalid", rvalid_o, 64'(1) << e[35:33]);
        chk("resp_err", err_o, e[32]);
        chk("resp_rdata", rdata_o, e[31:0]);
      end else begin
        chk("idle_rvalid", rvalid_o, 0);
      end
      win = -1;
      for (int k = 0; k < NR; k++) begin
        if (win < 0 && req[(ptr_m + k) % NR]) win = (ptr_m + k) % NR;
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      chk("gnt", gnt_o, eg);
      for (int i = 0; i < NR; i++) begin
        if (eg[i]) begin
          chk("starve_ok", wait_cnt[i] < NR, 1);
          wait_cnt[i] = 0;
        end else if (req[i]) begin
          wait_cnt[i]++;
        end
      end
      if (win >= 0) begin
        wd  = addr[win][8:2];
        oob = oob_of(addr[win]);
        chk("rom_a", rom_a_o, wd);
        chk("rom_cen", rom_cen_o, oob);
        exp_q.push_back({3'(win), oob, oob ? 32'h0 : mem[wd]});
        ptr_m    = (win + 1) % NR;
        last_a_m = wd;
      end else begin
        chk("idle_cen", rom_cen_o, 1);
        chk("idle_rom_a", rom_a_o, last_a_m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    logic [31:0] lits [3];
    logic [31:0] strm [4];
    logic [31:0] a;
    lits = '{32'h09C0006F, 32'h0980006F, 32'h0940006F};
    strm = '{32'h42203241, 32'h6C746F6F, 32'h6564616F, 32'h0A0D2072};
    for (int i = 0; i < 128; i++) mem[i] = (i < 118) ? {8'hB0, 8'(i), 16'h1234} : 32'h0;
    for (int i = 0; i < 3; i++) mem[i] = lits[i];
    for (int i = 0; i < 4; i++) mem[109 + i] = strm[i];
    mem[33] = 32'h0000006F;

    // Reset with all requesters asserted: grants must stay low.
    rst  = 1'b1;
    req  = '1;
    addr = '0;
    @(negedge clk);
    chk("rst_gnt_forced", gnt_o, 0);
    chk("rst_err", err_o, 0);
    step();
    req = '0;
    step();
    rst = 1'b0;

    // Three-way contention from a fresh pointer.
    addr[0] = 32'h0; addr[1] = 32'h4; addr[2] = 32'h8;
    req = 3'b111;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) chk("rr_order", gnt_o, 64'(1) << (k % 3));
      if (k > 0) begin
        chk("rr_rvalid", rvalid_o, 64'(1) << ((k - 1) % 3));
        chk("rr_rdata", rdata_o, lits[(k - 1) % 3]);
      end
      if (k == 5) begin
        step();
        req = '0;
      end
    end

    // Single read by requester 0 at word 33.
    step();
    req = 3'b001; addr[0] = 32'h84;
    @(negedge clk);
    chk("t1_gnt", gnt_o, 3'b001);
    chk("t1_rom_a", rom_a_o, 33);
    chk("t1_cen", rom_cen_o, 0);
    step();
    req = '0;
    @(negedge clk);
    chk("t1_rvalid", rvalid_o, 3'b001);
    chk("t1_rdata", rdata_o, 32'h0000006F);

    // Requester 1 streams four back-to-back reads.
    step();
    req = 3'b010; addr[1] = 32'h1B4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) chk("strm_gnt", gnt_o, 3'b010);
      if (k > 0) begin
        chk("strm_rvalid", rvalid_o, 3'b010);
        chk("strm_rdata", rdata_o, strm[k - 1]);
      end
      step();
      if (k < 3) addr[1] = 32'h1B4 + 32'(4 * (k + 1));
      else req = '0;
    end

    // Unaligned byte address maps to the same word.
    req = 3'b001; addr[0] = 32'h87;
    @(negedge clk);
    chk("unal_rom_a", rom_a_o, 33);
    step();
    req = '0;
    @(negedge clk);
    chk("unal_rdata", rdata_o, 32'h0000006F);

    // Grant to requester 2, then reset while the response is in flight.
    step();
    req = 3'b100; addr[2] = 32'h0;
    @(negedge clk);
    chk("rstmid_gnt", gnt_o, 3'b100);
    step();
    req = '0; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rvalid", rvalid_o, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rvalid_after", rvalid_o, 0);
    step();
    req = 3'b111; addr[0] = 32'h0; addr[1] = 32'h4; addr[2] = 32'h8;
    @(negedge clk);
    chk("rstmid_first_gnt", gnt_o, 3'b001);
    step();
    req = '0;
    repeat (3) step();

    // Read of word 118, just beyond the populated ROM.
    req = 3'b001; addr[0] = 32'h1D8;
    @(negedge clk);
    chk("oob_gnt", gnt_o, 3'b001);
`ifdef FPGA_BOOTROM_RANGE_CHECK_EN
    chk("oob_cen", rom_cen_o, 1);
`else
    chk("oob_cen", rom_cen_o, 0);
`endif
    step();
    req = '0;
    @(negedge clk);
    chk("oob_rvalid", rvalid_o, 3'b001);
    chk("oob_rdata", rdata_o, 0);
`ifdef FPGA_BOOTROM_RANGE_CHECK_EN
    chk("oob_err", err_o, 1);
`else
    chk("oob_err", err_o, 0);
`endif

    // Random traffic: requesters hold until granted, one reset pulse mid-run.
    for (int c = 0; c < 300; c++) begin
      step();
      rst = (c == 150);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && gnt_seen[i]) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) a = $urandom();
          else a = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
          addr[i] = a;
          req[i]  = 1'b1;
        end
      end
    end
    step();
    rst = 1'b0;
    req = '0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
